// File: rtl/hex_cell_emitter.sv
// hex_cell_emitter: cube-rounds one fractional hex coordinate per transaction and
// streams every integer cell within radius min(lod, MAX_RADIUS) of the rounded centre.
module hex_cell_emitter #(
    parameter int FRAC_W     = 16,
    parameter int COORD_W    = 16,
    parameter int MAX_RADIUS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_q_f,
    input  logic [31:0]        in_r_f,
    input  logic [31:0]        in_s_f,
    input  logic [7:0]         in_lod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_q,
    output logic [COORD_W-1:0] out_r,
    output logic [COORD_W-1:0] out_s,
    output logic               out_last,
    output logic               busy
);

    // Offsets span [-MAX_RADIUS, MAX_RADIUS]; the rounding datapath is widened so the
    // half-LSB add and the reconstruction shift can never overflow.
    localparam int OW = 10;
    localparam int XW = 34;
    localparam logic [8:0] MAX_LOD = 9'(MAX_RADIUS);
    localparam logic signed [XW-1:0] HALF = 34'sd1 <<< (FRAC_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_EMIT
    } state_t;

    state_t state, state_n;

    logic [31:0]              cap_q, cap_r, cap_s;
    logic [31:0]              cap_q_n, cap_r_n, cap_s_n;
    logic signed [OW-1:0]     rad, rad_n;
    logic signed [OW-1:0]     dq, dr, dq_n, dr_n;
    logic [COORD_W-1:0]       base_q, base_r, base_q_n, base_r_n;
    logic [COORD_W-1:0]       round_q, round_r;
    logic [COORD_W-1:0]       cell_q, cell_r;
    logic                     out_valid_n, out_last_n;

    logic signed [XW-1:0]     rx_q, rx_r, rx_s;
    logic [XW-1:0]            d_q, d_r, d_s;
    logic signed [XW-1:0]     fix_q, fix_r;

    function automatic logic signed [XW-1:0] round_fx(input logic [31:0] x);
        logic signed [XW-1:0] xe;
        xe = XW'($signed(x));
        return (xe + HALF) >>> FRAC_W;
    endfunction

    function automatic logic [XW-1:0] dist_fx(input logic [31:0] x,
                                              input logic signed [XW-1:0] rx);
        logic signed [XW-1:0] diff;
        diff = (rx <<< FRAC_W) - XW'($signed(x));
        return (diff < 0) ? XW'(-diff) : XW'(diff);
    endfunction

    function automatic logic signed [OW-1:0] dr_lo(input logic signed [OW-1:0] d,
                                                   input logic signed [OW-1:0] r);
        return (-d - r > -r) ? (-d - r) : -r;
    endfunction

    function automatic logic signed [OW-1:0] dr_hi(input logic signed [OW-1:0] d,
                                                   input logic signed [OW-1:0] r);
        return (r - d < r) ? (r - d) : r;
    endfunction

    assign in_ready = (state == S_IDLE) && !reset;
    assign busy     = (state != S_IDLE);

    // Cube rounding of the captured coordinate: the component with the largest
    // rounding error is rebuilt from the other two so the result sums to zero.
    always_comb begin
        rx_q  = round_fx(cap_q);
        rx_r  = round_fx(cap_r);
        rx_s  = round_fx(cap_s);
        d_q   = dist_fx(cap_q, rx_q);
        d_r   = dist_fx(cap_r, rx_r);
        d_s   = dist_fx(cap_s, rx_s);
        fix_q = rx_q;
        fix_r = rx_r;
        if (d_q > d_r && d_q > d_s) begin
            fix_q = -rx_r - rx_s;
        end else if (d_r > d_s) begin
            fix_r = -rx_q - rx_s;
        end
        round_q = fix_q[COORD_W-1:0];
        round_r = fix_r[COORD_W-1:0];
    end

    // Next-state, walk advance and the cell that will be presented next cycle.
    always_comb begin
        state_n     = state;
        cap_q_n     = cap_q;
        cap_r_n     = cap_r;
        cap_s_n     = cap_s;
        rad_n       = rad;
        dq_n        = dq;
        dr_n        = dr;
        base_q_n    = base_q;
        base_r_n    = base_r;
        out_valid_n = out_valid;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    cap_q_n = in_q_f;
                    cap_r_n = in_r_f;
                    cap_s_n = in_s_f;
                    rad_n   = ({1'b0, in_lod} > MAX_LOD) ? OW'(MAX_RADIUS) : OW'(in_lod);
                    state_n = S_ROUND;
                end
            end
            S_ROUND: begin
                base_q_n    = round_q;
                base_r_n    = round_r;
                dq_n        = -rad;
                dr_n        = dr_lo(-rad, rad);
                out_valid_n = 1'b1;
                state_n     = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        out_valid_n = 1'b0;
                        state_n     = S_IDLE;
                    end else if (dr < dr_hi(dq, rad)) begin
                        dr_n = dr + 1'b1;
                    end else begin
                        dq_n = dq + 1'b1;
                        dr_n = dr_lo(dq + 1'b1, rad);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        cell_q     = base_q_n + COORD_W'(dq_n);
        cell_r     = base_r_n + COORD_W'(dr_n);
        out_last_n = out_valid_n && (dq_n == rad_n) && (dr_n == dr_hi(dq_n, rad_n));
    end

    // State and datapath registers; reset aborts any walk in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cap_q     <= '0;
            cap_r     <= '0;
            cap_s     <= '0;
            rad       <= '0;
            dq        <= '0;
            dr        <= '0;
            base_q    <= '0;
            base_r    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_s     <= '0;
        end else begin
            state     <= state_n;
            cap_q     <= cap_q_n;
            cap_r     <= cap_r_n;
            cap_s     <= cap_s_n;
            rad       <= rad_n;
            dq        <= dq_n;
            dr        <= dr_n;
            base_q    <= base_q_n;
            base_r    <= base_r_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            out_q     <= cell_q;
            out_r     <= cell_r;
            out_s     <= -(cell_q + cell_r);
        end
    end

endmodule

// File: tb/tb_hex_cell_emitter.sv
// tb_hex_cell_emitter: directed and randomized transactions checked against a
// real-arithmetic cube-rounding and hex-ring walk model.
module tb_hex_cell_emitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_q_f = '0, in_r_f = '0, in_s_f = '0;
    logic [7:0]  in_lod = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_q, out_r, out_s;
    logic        out_last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int exp_r[$];
    int exp_rad;

    hex_cell_emitter #(.FRAC_W(16), .COORD_W(16), .MAX_RADIUS(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_q_f(in_q_f), .in_r_f(in_r_f), .in_s_f(in_s_f), .in_lod(in_lod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_s(out_s),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap16(input longint v);
        logic signed [15:0] t;
        t = 16'(v);
        return int'(t);
    endfunction

    function automatic longint round_comp(input logic [31:0] x, output real d);
        real xr, f;
        xr = $itor($signed(x)) / 65536.0;
        f  = $floor(xr + 0.5);
        d  = (f > xr) ? (f - xr) : (xr - f);
        return longint'($rtoi(f));
    endfunction

    // Expected cell list: centre from cube rounding, then rows of constant dq.
    function automatic void build_model(input logic [31:0] q, input logic [31:0] r,
                                        input logic [31:0] s, input logic [7:0] lod);
        real dq, dr, ds;
        longint cq, cr, cs;
        int rad, lo, hi;
        cq = round_comp(q, dq);
        cr = round_comp(r, dr);
        cs = round_comp(s, ds);
        if (dq > dr && dq > ds)  cq = -cr - cs;
        else if (dr > ds)        cr = -cq - cs;
        rad = (lod > 3) ? 3 : int'(lod);
        exp_rad = rad;
        exp_q.delete();
        exp_r.delete();
        for (int a = -rad; a <= rad; a++) begin
            lo = (-a - rad > -rad) ? -a - rad : -rad;
            hi = (rad - a < rad) ? rad - a : rad;
            for (int b = lo; b <= hi; b++) begin
                exp_q.push_back(wrap16(cq + a));
                exp_r.push_back(wrap16(cr + b));
            end
        end
    endfunction

    task automatic run_txn(input logic [31:0] q, input logic [31:0] r, input logic [31:0] s,
                           input logic [7:0] lod, input int pct, input int stall_at,
                           input int abort_at);
        int w, idx, guard, stall, n;
        logic held, done;
        logic [15:0] pq, pr, ps;
        logic pl;
        build_model(q, r, s, lod);
        n = exp_q.size();
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_q_f = q; in_r_f = r; in_s_f = s; in_lod = lod;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_round_valid", out_valid, 0);
        check("lat_round_busy", busy, 1);
        check("lat_round_ready", in_ready, 0);
        @(negedge clk);
        check("lat_first_valid", out_valid, 1);
        idx = 0; guard = 0; stall = 0; held = 1'b0; done = 1'b0;
        pq = '0; pr = '0; ps = '0; pl = 1'b0;
        while (guard < 3000 && !done) begin
            if (abort_at >= 0 && idx == abort_at) begin
                reset = 1'b1;
                out_ready = 1'b0;
                @(negedge clk);
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                reset = 1'b0;
                #1;
                check("abort_in_ready", in_ready, 1);
                return;
            end
            if (!out_valid) begin
                check("valid_drop", 0, 1);
                return;
            end
            check("emit_busy", busy, 1);
            if (held) begin
                check("hold_q", out_q, pq);
                check("hold_r", out_r, pr);
                check("hold_s", out_s, ps);
                check("hold_last", out_last, pl);
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(0, 99) < pct);
            end
            if (out_ready) begin
                check("cell_q", $signed(out_q), exp_q[idx]);
                check("cell_r", $signed(out_r), exp_r[idx]);
                check("cell_s", $signed(out_s), wrap16(-longint'(exp_q[idx]) - exp_r[idx]));
                check("cell_last", out_last, (idx == n - 1));
                idx++;
                if (idx == stall_at) stall = 5;
                done = out_last || idx >= n;
                held = 1'b0;
            end else begin
                held = 1'b1;
                pq = out_q; pr = out_r; ps = out_s; pl = out_last;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (!done) begin
            check("emit_timeout", 0, 1);
            return;
        end
        check("cell_count", idx, 3 * exp_rad * (exp_rad + 1) + 1);
        check("end_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
    endtask

    initial begin
        int q, r, s;
        logic [31:0] qv;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_q", out_q, 0);
        check("rst_s", out_s, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed cases
        run_txn(32'h00014000, 32'hFFFF8000, 32'hFFFF4000, 8'd0, 100, -1, -1);
        run_txn(32'h0000999A, 32'h0000999A, 32'hFFFECCCD, 8'd0, 100, -1, -1);
        run_txn(32'h00000000, 32'h00000000, 32'h00000000, 8'd1, 100, -1, -1);
        run_txn(32'h00050000, 32'hFFFD0000, 32'hFFFE0000, 8'd9, 100, -1, -1);
        run_txn(32'h00020000, 32'h00010000, 32'hFFFD0000, 8'd2, 100, 4, -1);
        run_txn(32'h00010000, 32'h00010000, 32'hFFFE0000, 8'd3, 100, -1, 5);
        run_txn(32'h00030000, 32'hFFFF0000, 32'hFFFE0000, 8'd0, 100, -1, -1);
        // Coordinates near the signed 16-bit edge exercise output wrap-around
        run_txn(32'h7FFF0000, 32'h80010000, 32'h00000000, 8'd2, 100, -1, -1);

        // Randomized transactions with random backpressure
        for (int t = 0; t < 30; t++) begin
            q = (int'($urandom_range(0, 400)) - 200) * 65536 + int'($urandom_range(0, 65535)) - 32768;
            r = (int'($urandom_range(0, 400)) - 200) * 65536 + int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 3) == 0) begin
                qv = q;
                qv[15:0] = 16'h8000;
                q = qv;
            end
            s = -(q + r);
            if ($urandom_range(0, 2) == 0) s = s + int'($urandom_range(0, 40000)) - 20000;
            run_txn(q, r, s, 8'($urandom_range(0, 6)), 70, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
